bk_adder_bist: RTL and testbench

BK_ADDER_BIST -- requirements
Module: bk_adder_bist

---
 rtl/bk_adder_bist.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_bk_adder_bist.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_adder_bist.sv
// ============================================================================
// bk_adder_bist
//
// Built-in self test sequencer for an external N-bit adder (typically a
// Brent-Kung prefix adder). A run launches 8 directed vectors and then
// NUM_RAND vectors from a 32-bit Galois LFSR. Each launched vector's
// expected (N+1)-bit sum travels down a LAT-deep pipeline. It is compared
// with Sum when it reaches the end of that pipeline.
//
// Ports
//   clk      in   1      single clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request a run (honoured only in IDLE or DONE)
//   A, B     out  N      registered operands to the adder under test
//   Cin      out  1      registered carry-in to the adder under test
//   Sum      in   N+1    adder result, Sum[N] is the carry-out
//   busy     out  1      run in progress
//   done     out  1      level, run finished (until the next accepted start)
//   pass     out  1      valid with done, 1 when no mismatch was seen
//   err_cnt  out  16     saturating mismatch count
//   err_vec  out  2N+1   {Cin,B,A} of the first mismatching vector
//
// Optional build macro
//   BK_BIST_STOP_ON_ERR_EN  when defined, the first mismatch stops further
//                           launches, flushes in-flight compares and drains.
//
// Timeline with the start-accept edge as edge 0
//   - Directed vectors are launched at edges 1..8.
//   - Random vectors are launched at edges 9..8+NUM_RAND.
//   - RANDOM then spends one bubble cycle with no launch.
//   - DRAIN lasts LAT cycles.
//   - DONE is entered at edge 8+NUM_RAND+LAT+1.
// ============================================================================
module bk_adder_bist #(
    parameter int          N        = 32,
    parameter int          NUM_RAND = 1024,
    parameter int          LAT      = 1,
    parameter logic [31:0] SEED     = 32'hACE1_2468
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [N-1:0]   A,
    output logic [N-1:0]   B,
    output logic           Cin,
    input  logic [N:0]     Sum,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [15:0]    err_cnt,
    output logic [2*N:0]   err_vec
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DIRECTED = 3'd1,
        S_RANDOM   = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [15:0] RAND_CNT   = 16'(NUM_RAND);
    localparam logic [15:0] DRAIN_LAST = 16'(LAT - 1);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // One step of the Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        if (s[0]) begin
            lfsr_next = {1'b0, s[31:1]} ^ LFSR_TAPS;
        end else begin
            lfsr_next = {1'b0, s[31:1]};
        end
    endfunction

    // Random vector packed as {Cin,B,A}.
    // B is taken from the bit-reversed LFSR state.
    function automatic logic [2*N:0] random_vec(input logic [31:0] s);
        logic [31:0] rev;
        rev = 32'd0;
        for (int i = 0; i < 32; i++) begin
            rev[i] = s[31-i];
        end
        random_vec = {s[0] ^ s[31], rev[N-1:0], s[N-1:0]};
    endfunction

    // Directed corner vectors, packed as {Cin,B,A}.
    // They cover the zero cases, full carry ripple, the alternating
    // pattern, the low-bit ripple and the MSB-only carry.
    function automatic logic [2*N:0] directed_vec(input logic [2:0] idx);
        logic [N-1:0] ones;
        logic [N-1:0] zero;
        logic [N-1:0] alt;
        logic [N-1:0] msb;
        logic [N-1:0] one;
        ones = {N{1'b1}};
        zero = {N{1'b0}};
        msb  = {1'b1, {(N-1){1'b0}}};
        one  = {{(N-1){1'b0}}, 1'b1};
        alt  = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            alt[i] = ((i % 2) == 0);
        end
        case (idx)
            3'd0:    directed_vec = {1'b0, zero, zero};
            3'd1:    directed_vec = {1'b1, zero, zero};
            3'd2:    directed_vec = {1'b1, zero, ones};
            3'd3:    directed_vec = {1'b0, ones, ones};
            3'd4:    directed_vec = {1'b1, ones, ones};
            3'd5:    directed_vec = {1'b1, ~alt, alt};
            3'd6:    directed_vec = {1'b0, ones, one};
            3'd7:    directed_vec = {1'b0, msb, msb};
            default: directed_vec = {(2*N+1){1'b0}};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state_q,   state_d;
    logic [15:0]              cnt_q,     cnt_d;
    logic [31:0]              lfsr_q,    lfsr_d;
    logic [N-1:0]             a_q,       a_d;
    logic [N-1:0]             b_q,       b_d;
    logic                     cin_q,     cin_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;
    logic                     pass_q,    pass_d;
    logic [15:0]              err_cnt_q, err_cnt_d;
    logic [2*N:0]             err_vec_q, err_vec_d;
    // Expected-value pipeline: valid flag, expected sum and source vector.
    logic [LAT-1:0]           vld_q,     vld_d;
    logic [LAT-1:0][N:0]      exp_q,     exp_d;
    logic [LAT-1:0][2*N:0]    vec_q,     vec_d;

    logic                     launch_s;
    logic [2*N:0]             launch_vec_s;
    logic                     mismatch_s;
    logic                     flush_s;

    // Next-state, launch, compare and pipeline logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lfsr_d       = lfsr_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        err_vec_d    = err_vec_q;
        launch_s     = 1'b0;
        launch_vec_s = {(2*N+1){1'b0}};
        flush_s      = 1'b0;
        vld_d        = {LAT{1'b0}};
        exp_d        = exp_q;
        vec_d        = vec_q;

        // The oldest pipeline stage lines up with the Sum being sampled now.
        mismatch_s = vld_q[LAT-1] & (Sum != exp_q[LAT-1]);

        if (mismatch_s) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (err_cnt_q == 16'd0) begin
                err_vec_d = vec_q[LAT-1];
            end else begin
                err_vec_d = err_vec_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
            err_vec_d = err_vec_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_DIRECTED;
                    cnt_d     = 16'd0;
                    lfsr_d    = SEED;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = 16'd0;
                    err_vec_d = {(2*N+1){1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_DIRECTED: begin
                launch_s     = 1'b1;
                launch_vec_s = directed_vec(cnt_q[2:0]);
                if (cnt_q == 16'd7) begin
                    state_d = S_RANDOM;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RANDOM: begin
                // After the last launch, one bubble cycle lets the final
                // vector be sampled before DRAIN starts.
                if (cnt_q < RAND_CNT) begin
                    launch_s     = 1'b1;
                    launch_vec_s = random_vec(lfsr_q);
                    lfsr_d       = lfsr_next(lfsr_q);
                    cnt_d        = cnt_q + 16'd1;
                end else begin
                    state_d = S_DRAIN;
                    cnt_d   = 16'd0;
                end
            end
            S_DRAIN: begin
                if (cnt_q >= DRAIN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = 16'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 16'd0);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase

`ifdef BK_BIST_STOP_ON_ERR_EN
        // Stop at the first miscompare.
        // The launch for this cycle is cancelled, the LFSR is frozen, the
        // in-flight compares are flushed, and the run drains for LAT cycles.
        if (mismatch_s && busy_q) begin
            launch_s = 1'b0;
            flush_s  = 1'b1;
            lfsr_d   = lfsr_q;
            state_d  = S_DRAIN;
            cnt_d    = 16'd0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pass_d   = 1'b0;
        end else begin
            flush_s = 1'b0;
        end
`endif

        if (launch_s) begin
            a_d   = launch_vec_s[N-1:0];
            b_d   = launch_vec_s[2*N-1:N];
            cin_d = launch_vec_s[2*N];
        end else begin
            a_d   = a_q;
            b_d   = b_q;
            cin_d = cin_q;
        end

        // The expected sum is computed at launch and ages alongside its vector.
        vld_d[0] = launch_s & ~flush_s;
        exp_d[0] = {1'b0, launch_vec_s[N-1:0]} + {1'b0, launch_vec_s[2*N-1:N]}
                 + {{N{1'b0}}, launch_vec_s[2*N]};
        vec_d[0] = launch_vec_s;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~flush_s;
            exp_d[i] = exp_q[i-1];
            vec_d[i] = vec_q[i-1];
        end
    end

    // All state registers, with asynchronous reset to IDLE and LFSR=SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            lfsr_q    <= SEED;
            a_q       <= {N{1'b0}};
            b_q       <= {N{1'b0}};
            cin_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 16'd0;
            err_vec_q <= {(2*N+1){1'b0}};
            vld_q     <= {LAT{1'b0}};
            exp_q     <= {(LAT*(N+1)){1'b0}};
            vec_q     <= {(LAT*(2*N+1)){1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            err_vec_q <= err_vec_d;
            vld_q     <= vld_d;
            exp_q     <= exp_d;
            vec_q     <= vec_d;
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign Cin     = cin_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;
    assign err_vec = err_vec_q;

endmodule

// File: tb/tb_bk_adder_bist.sv
// ============================================================================
// tb_bk_adder_bist
//
// Drives bk_adder_bist (N=32, NUM_RAND=1024, LAT=1) against a behavioural
// adder with selectable faults:
//   0  correct adder
//   1  carry-out stuck at 0
//   2  carry-in ignored
//
// For each run, a reference model builds the full vector list from the
// described rules. From that list it derives:
//   - the operand sequence,
//   - the mismatch count,
//   - the first failing vector,
//   - the edge on which done rises.
// ============================================================================
module tb_bk_adder_bist;

    localparam int          N    = 32;
    localparam int          NR   = 1024;
    localparam int          LAT  = 1;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    typedef struct packed {
        logic          cin;
        logic [N-1:0]  b;
        logic [N-1:0]  a;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           Cin;
    logic [N:0]     Sum;
    logic           busy;
    logic           done;
    logic           pass;
    logic [15:0]    err_cnt;
    logic [2*N:0]   err_vec;

    int             fault_mode;
    int             tests;
    int             fails;

    vec_t           vecs[$];
    int             exp_nl;
    int             exp_done_edge;
    int             exp_errs;
    vec_t           exp_first;

    bk_adder_bist #(.N(N), .NUM_RAND(NR), .LAT(LAT), .SEED(SEED)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .Sum     (Sum),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .err_vec (err_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // True sum of a vector, computed in wide integer arithmetic.
    function automatic logic [N:0] good_sum(input vec_t v);
        longint unsigned t;
        t = longint'(v.a) + longint'(v.b) + longint'(v.cin);
        good_sum = t[N:0];
    endfunction

    // Sum produced by the adder under test for the selected fault.
    function automatic logic [N:0] faulty_sum(input vec_t v, input int fm);
        logic [N:0] s;
        s = good_sum(v);
        if (fm == 1) begin
            s[N] = 1'b0;
        end else if (fm == 2) begin
            s = good_sum('{cin: 1'b0, b: v.b, a: v.a});
        end
        return s;
    endfunction

    // The adder under test is combinational, matching LAT = 1.
    assign Sum = faulty_sum('{cin: Cin, b: B, a: A}, fault_mode);

    function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.cin = c;
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build the vector list and the outcome expected for fault mode fm.
    task automatic build_model(input int fm);
        logic [31:0] s;
        logic [31:0] rev;
        int          first;
        vecs.delete();
        vecs.push_back(mk(32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(ONES, 32'h0, 1'b1));
        vecs.push_back(mk(ONES, ONES, 1'b0));
        vecs.push_back(mk(ONES, ONES, 1'b1));
        vecs.push_back(mk(32'h5555_5555, 32'hAAAA_AAAA, 1'b1));
        vecs.push_back(mk(32'h0000_0001, ONES, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0));
        s = SEED;
        for (int i = 0; i < NR; i++) begin
            rev = {<<{s}};
            vecs.push_back(mk(s, rev, s[0] ^ s[31]));
            s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
        end
        exp_errs = 0;
        first    = -1;
        foreach (vecs[i]) begin
            if (faulty_sum(vecs[i], fm) != good_sum(vecs[i])) begin
                exp_errs++;
                if (first < 0) first = i;
            end
        end
        exp_nl        = vecs.size();
        exp_done_edge = 8 + NR + LAT + 1;
`ifdef BK_BIST_STOP_ON_ERR_EN
        if (first >= 0) begin
            exp_errs      = 1;
            exp_nl        = (first + LAT < exp_nl) ? first + LAT : exp_nl;
            exp_done_edge = first + 1 + 2 * LAT;
        end
`endif
        if (exp_errs > 65535) exp_errs = 65535;
        exp_first = (first >= 0) ? vecs[first] : '0;
    endtask

    // One run.
    //   release_rst : deasserts rst_n together with start
    //   hammer      : keeps start high throughout the run
    //   abort_at    : >0 pulses reset right after that edge and returns
    task automatic do_run(input int fm, input bit release_rst, input bit hammer, input int abort_at);
        int first_done;
        int idx;
        build_model(fm);
        fault_mode = fm;
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hammer) start = 1'b0;
        check("accept_busy",    {127'd0, busy}, 128'd1);
        check("accept_done",    {127'd0, done}, 128'd0);
        check("accept_err_cnt", {112'd0, err_cnt}, 128'd0);
        check("accept_err_vec", {63'd0, err_vec}, 128'd0);
        first_done = -1;
        for (int k = 1; k <= exp_done_edge + 8; k++) begin
            @(posedge clk);
            #1;
            idx = (k - 1 < exp_nl) ? k - 1 : exp_nl - 1;
            if (k <= exp_done_edge) check("launch_vec", {63'd0, Cin, B, A}, {63'd0, vecs[idx]});
            if (abort_at == k) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_ops",     {63'd0, Cin, B, A}, 128'd0);
                check("rst_flags",   {125'd0, busy, done, pass}, 128'd0);
                check("rst_err_cnt", {112'd0, err_cnt}, 128'd0);
                check("rst_err_vec", {63'd0, err_vec}, 128'd0);
                start = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (6) @(posedge clk);
                #1;
                check("post_rst_idle", {125'd0, busy, done, pass}, 128'd0);
                check("post_rst_ops",  {63'd0, Cin, B, A}, 128'd0);
                return;
            end
            if (done === 1'b1) begin
                first_done = k;
                break;
            end
        end
        start = 1'b0;
        check("done_edge", 128'(first_done), 128'(exp_done_edge));
        check("end_busy",    {127'd0, busy}, 128'd0);
        check("end_pass",    {127'd0, pass}, {127'd0, (exp_errs == 0)});
        check("end_err_cnt", {112'd0, err_cnt}, 128'(exp_errs));
        check("end_err_vec", {63'd0, err_vec}, {63'd0, exp_first});
        repeat (3) @(negedge clk);
        check("done_level", {127'd0, done}, 128'd1);
        check("hold_ops", {63'd0, Cin, B, A}, {63'd0, vecs[exp_nl-1]});
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        fault_mode = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ops",     {63'd0, Cin, B, A}, 128'd0);
        check("reset_flags",   {125'd0, busy, done, pass}, 128'd0);
        check("reset_err_cnt", {112'd0, err_cnt}, 128'd0);
        check("reset_err_vec", {63'd0, err_vec}, 128'd0);

        do_run(0, 1'b1, 1'b0, 0);   // good adder, start on first edge after reset
        do_run(1, 1'b0, 1'b0, 0);   // carry-out stuck at 0
        do_run(2, 1'b0, 1'b0, 0);   // carry-in ignored
        do_run(0, 1'b0, 1'b1, 0);   // start held high all run, launched from DONE
        do_run(0, 1'b0, 1'b0, 109); // reset pulsed right after random vector 100
        do_run(0, 1'b0, 1'b0, 0);   // rerun after reset repeats the same sequence

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall time bound.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
